// File: rtl/setting_pkg.sv
// Shared encodings for the clock front-panel setting controller.
package setting_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_TSET  = 2'd1,
        MODE_ASET  = 2'd2,
        MODE_SW    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    function automatic logic is_set_mode(input mode_t mode);
        return (mode == MODE_TSET) || (mode == MODE_ASET);
    endfunction

endpackage

// File: rtl/sw_edge.sv
// Rising-edge press detector for one debounced switch level.
// A level already high when reset is released is not reported as a press.
module sw_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_press
);

    logic prev_q;
    logic armed_q;

    // Previous level, plus an arm flag so the first sampled cycle never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= i_lvl;
            armed_q <= 1'b1;
        end
    end

    assign o_press = i_lvl & ~prev_q & armed_q;

endmodule

// File: rtl/setting_ctrl.sv
// Front-panel setting controller: mode/position FSM, increment strobes and
// inactivity timeout. Define SETTING_AUTO_REPEAT_EN for hold-to-repeat increments.
module setting_ctrl
    import setting_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int CNT_W          = 32,
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_up,
    output logic [1:0] o_setting_mode,
    output logic [1:0] o_setting_position,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic       o_timeout
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic mode_press_s, pos_press_s, up_press_s;
    logic up_evt_s, rpt_fire_s, expire_s, set_mode_s;

    mode_t            mode_q, mode_d;
    pos_t             pos_q, pos_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             inc_sec_q, inc_min_q, inc_hour_q, timeout_q;
    logic             inc_sec_d, inc_min_d, inc_hour_d, timeout_d;

    sw_edge u_edge_mode (.clk(clk), .rst_n(rst_n), .i_lvl(i_sw_mode), .o_press(mode_press_s));
    sw_edge u_edge_pos  (.clk(clk), .rst_n(rst_n), .i_lvl(i_sw_pos),  .o_press(pos_press_s));
    sw_edge u_edge_up   (.clk(clk), .rst_n(rst_n), .i_lvl(i_sw_up),   .o_press(up_press_s));

    assign set_mode_s = is_set_mode(mode_q);
    // An up press only counts when no higher-priority press shares its cycle.
    assign up_evt_s   = up_press_s & ~mode_press_s & ~pos_press_s & set_mode_s;
    assign expire_s   = ~mode_press_s & ~pos_press_s & ~up_press_s & ~rpt_fire_s
                        & set_mode_s & (tmo_cnt_q == TMO_LAST);

`ifdef SETTING_AUTO_REPEAT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             hold_ok_s;

    // hold_cnt_q counts cycles since the last strobe while up stays held; 0 = idle.
    assign hold_ok_s  = i_sw_up & set_mode_s & ~mode_press_s & ~pos_press_s & ~up_press_s
                        & (hold_cnt_q != {CNT_W{1'b0}});
    assign rpt_fire_s = hold_ok_s & (rpt_phase_q ? (hold_cnt_q == CNT_W'(REPEAT_PERIOD))
                                                 : (hold_cnt_q == CNT_W'(REPEAT_DELAY)));

    // Hold counter next state: restart on a fresh press, reload on each repeat.
    always_comb begin
        hold_cnt_d  = {CNT_W{1'b0}};
        rpt_phase_d = 1'b0;
        if (up_evt_s) begin
            hold_cnt_d  = CNT_W'(1);
            rpt_phase_d = 1'b0;
        end else if (hold_ok_s && !expire_s) begin
            if (rpt_fire_s) begin
                hold_cnt_d  = CNT_W'(1);
                rpt_phase_d = 1'b1;
            end else begin
                hold_cnt_d  = hold_cnt_q + CNT_W'(1);
                rpt_phase_d = rpt_phase_q;
            end
        end else begin
            hold_cnt_d  = {CNT_W{1'b0}};
            rpt_phase_d = 1'b0;
        end
    end

    // Hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q  <= {CNT_W{1'b0}};
            rpt_phase_q <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_CLOCK;
            pos_q      <= POS_SEC;
            tmo_cnt_q  <= {CNT_W{1'b0}};
            inc_sec_q  <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_hour_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            tmo_cnt_q  <= tmo_cnt_d;
            inc_sec_q  <= inc_sec_d;
            inc_min_q  <= inc_min_d;
            inc_hour_q <= inc_hour_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next mode, position and inactivity count, in press-priority order.
    always_comb begin
        mode_d    = mode_q;
        pos_d     = pos_q;
        tmo_cnt_d = tmo_cnt_q;
        if (mode_press_s) begin
            case (mode_q)
                MODE_CLOCK: mode_d = MODE_TSET;
                MODE_TSET:  mode_d = MODE_ASET;
                MODE_ASET:  mode_d = MODE_SW;
                MODE_SW:    mode_d = MODE_CLOCK;
                default:    mode_d = MODE_CLOCK;
            endcase
            pos_d     = POS_SEC;
            tmo_cnt_d = {CNT_W{1'b0}};
        end else if (pos_press_s) begin
            if (set_mode_s) begin
                case (pos_q)
                    POS_SEC:  pos_d = POS_MIN;
                    POS_MIN:  pos_d = POS_HOUR;
                    POS_HOUR: pos_d = POS_SEC;
                    default:  pos_d = POS_SEC;
                endcase
            end else begin
                pos_d = POS_SEC;
            end
            tmo_cnt_d = {CNT_W{1'b0}};
        end else if (up_press_s || rpt_fire_s || !set_mode_s) begin
            tmo_cnt_d = {CNT_W{1'b0}};
        end else if (expire_s) begin
            mode_d    = MODE_CLOCK;
            pos_d     = POS_SEC;
            tmo_cnt_d = {CNT_W{1'b0}};
        end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    // Strobe decode: one increment line per position, plus the timeout pulse.
    always_comb begin
        inc_sec_d  = 1'b0;
        inc_min_d  = 1'b0;
        inc_hour_d = 1'b0;
        timeout_d  = expire_s;
        if (up_evt_s || rpt_fire_s) begin
            case (pos_q)
                POS_SEC:  inc_sec_d  = 1'b1;
                POS_MIN:  inc_min_d  = 1'b1;
                POS_HOUR: inc_hour_d = 1'b1;
                default:  inc_sec_d  = 1'b0;
            endcase
        end else begin
            inc_sec_d = 1'b0;
        end
    end

    assign o_setting_mode     = mode_q;
    assign o_setting_position = pos_q;
    assign o_inc_sec          = inc_sec_q;
    assign o_inc_min          = inc_min_q;
    assign o_inc_hour         = inc_hour_q;
    assign o_timeout          = timeout_q;

endmodule

// File: tb/tb_setting_ctrl.sv
// Directed self-checking bench for setting_ctrl (short timeout/repeat parameters).
module tb_setting_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_sw_mode = 1'b0;
    logic       i_sw_pos = 1'b0;
    logic       i_sw_up = 1'b0;
    logic [1:0] o_setting_mode;
    logic [1:0] o_setting_position;
    logic       o_inc_sec, o_inc_min, o_inc_hour, o_timeout;

    int checks = 0;
    int failures = 0;

    setting_ctrl #(
        .TIMEOUT_CYCLES(100),
        .CNT_W(32),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_sw_mode(i_sw_mode),
        .i_sw_pos(i_sw_pos),
        .i_sw_up(i_sw_up),
        .o_setting_mode(o_setting_mode),
        .o_setting_position(o_setting_position),
        .o_inc_sec(o_inc_sec),
        .o_inc_min(o_inc_min),
        .o_inc_hour(o_inc_hour),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one switch high for exactly one sampled cycle; outputs then show the response.
    task automatic tap(input int sel);
        case (sel)
            0: i_sw_mode = 1'b1;
            1: i_sw_pos  = 1'b1;
            default: i_sw_up = 1'b1;
        endcase
        tick();
        i_sw_mode = 1'b0;
        i_sw_pos  = 1'b0;
        i_sw_up   = 1'b0;
    endtask

    task automatic tap_idle(input int sel);
        tap(sel);
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_sw_mode = 1'b1;
        #12;
        checks++;
        if ({o_setting_mode, o_setting_position, o_inc_sec, o_inc_min, o_inc_hour, o_timeout} !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got %b expected 00000000",
                     {o_setting_mode, o_setting_position, o_inc_sec, o_inc_min, o_inc_hour, o_timeout});
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (o_setting_mode !== 2'd0) begin
            failures++;
            $display("FAIL held_at_reset: mode got %0d expected 0", o_setting_mode);
        end
        i_sw_mode = 1'b0;
        tick();
    endtask

    task automatic test_mode_cycle;
        logic [1:0] exp_mode;
        for (int k = 1; k <= 4; k++) begin
            exp_mode = 2'(k % 4);
            tap(0);
            checks++;
            if (o_setting_mode !== exp_mode || o_setting_position !== 2'd0) begin
                failures++;
                $display("FAIL mode_cycle[%0d]: mode/pos got %0d/%0d expected %0d/0",
                         k, o_setting_mode, o_setting_position, exp_mode);
            end
            tick();
        end
    endtask

    task automatic test_position;
        logic [1:0] exp_pos [3];
        exp_pos[0] = 2'd1; exp_pos[1] = 2'd2; exp_pos[2] = 2'd0;
        tap_idle(0);
        for (int k = 0; k < 3; k++) begin
            tap(1);
            checks++;
            if (o_setting_position !== exp_pos[k] || o_setting_mode !== 2'd1) begin
                failures++;
                $display("FAIL pos_advance[%0d]: pos got %0d expected %0d", k, o_setting_position, exp_pos[k]);
            end
            tick();
        end
        tap_idle(0); tap_idle(0); tap_idle(0);
        tap(1);
        checks++;
        if (o_setting_position !== 2'd0 || o_setting_mode !== 2'd0) begin
            failures++;
            $display("FAIL pos_in_clock: mode/pos got %0d/%0d expected 0/0", o_setting_mode, o_setting_position);
        end
        tick();
    endtask

    task automatic test_increment;
        tap_idle(0);
        tap_idle(1);
        i_sw_up = 1'b1;
        tick();
        checks++;
        if ({o_inc_hour, o_inc_min, o_inc_sec} !== 3'b010) begin
            failures++;
            $display("FAIL inc_min: hour/min/sec got %b expected 010", {o_inc_hour, o_inc_min, o_inc_sec});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({o_inc_hour, o_inc_min, o_inc_sec} !== 3'b000) begin
                failures++;
                $display("FAIL inc_single[%0d]: got %b expected 000", k, {o_inc_hour, o_inc_min, o_inc_sec});
            end
        end
        i_sw_up = 1'b0;
        tick();
        tap_idle(1);
        tap(2);
        checks++;
        if ({o_inc_hour, o_inc_min, o_inc_sec} !== 3'b100) begin
            failures++;
            $display("FAIL inc_hour: got %b expected 100", {o_inc_hour, o_inc_min, o_inc_sec});
        end
        tick();
        tap_idle(0);
        tap(2);
        checks++;
        if ({o_inc_hour, o_inc_min, o_inc_sec} !== 3'b001 || o_setting_mode !== 2'd2) begin
            failures++;
            $display("FAIL inc_sec_aset: got %b mode %0d expected 001 mode 2",
                     {o_inc_hour, o_inc_min, o_inc_sec}, o_setting_mode);
        end
        tick();
        tap_idle(0);
        tap(2);
        checks++;
        if ({o_inc_hour, o_inc_min, o_inc_sec} !== 3'b000 || o_setting_mode !== 2'd3) begin
            failures++;
            $display("FAIL inc_stopwatch: got %b mode %0d expected 000 mode 3",
                     {o_inc_hour, o_inc_min, o_inc_sec}, o_setting_mode);
        end
        tick();
        tap_idle(0);
    endtask

    task automatic test_timeout;
        int seen;
        tap_idle(0);
        tap_idle(0);
        tap(1);
        tick(99);
        checks++;
        if (o_timeout !== 1'b0 || o_setting_mode !== 2'd2) begin
            failures++;
            $display("FAIL tmo_early: timeout/mode got %b/%0d expected 0/2", o_timeout, o_setting_mode);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b1 || o_setting_mode !== 2'd0 || o_setting_position !== 2'd0) begin
            failures++;
            $display("FAIL tmo_fire: timeout/mode/pos got %b/%0d/%0d expected 1/0/0",
                     o_timeout, o_setting_mode, o_setting_position);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL tmo_pulse: timeout got %b expected 0", o_timeout);
        end
        tap_idle(0);
        tap(0);
        tick(99);
        i_sw_pos = 1'b1;
        tick();
        i_sw_pos = 1'b0;
        checks++;
        if (o_timeout !== 1'b0 || o_setting_mode !== 2'd2 || o_setting_position !== 2'd1) begin
            failures++;
            $display("FAIL tmo_press_wins: timeout/mode/pos got %b/%0d/%0d expected 0/2/1",
                     o_timeout, o_setting_mode, o_setting_position);
        end
        tick();
        tap_idle(0);
        seen = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (o_timeout !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || o_setting_mode !== 2'd3) begin
            failures++;
            $display("FAIL sw_no_timeout: timeout pulses %0d mode %0d expected 0 pulses mode 3", seen, o_setting_mode);
        end
        tap_idle(0);
    endtask

    task automatic test_priority;
        tap_idle(0);
        tap_idle(1);
        i_sw_mode = 1'b1;
        i_sw_up   = 1'b1;
        tick();
        i_sw_mode = 1'b0;
        i_sw_up   = 1'b0;
        checks++;
        if (o_setting_mode !== 2'd2 || o_setting_position !== 2'd0
            || {o_inc_hour, o_inc_min, o_inc_sec} !== 3'b000) begin
            failures++;
            $display("FAIL prio_mode_up: mode/pos/inc got %0d/%0d/%b expected 2/0/000",
                     o_setting_mode, o_setting_position, {o_inc_hour, o_inc_min, o_inc_sec});
        end
        tick();
        checks++;
        if ({o_inc_hour, o_inc_min, o_inc_sec} !== 3'b000) begin
            failures++;
            $display("FAIL prio_not_queued: inc got %b expected 000", {o_inc_hour, o_inc_min, o_inc_sec});
        end
        tap_idle(0);
        tap_idle(0);
    endtask

    task automatic test_reset_mid;
        tap_idle(0);
        i_sw_up = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_setting_mode, o_setting_position, o_inc_sec, o_inc_min, o_inc_hour, o_timeout} !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid: got %b expected 00000000",
                     {o_setting_mode, o_setting_position, o_inc_sec, o_inc_min, o_inc_hour, o_timeout});
        end
        #10;
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (o_setting_mode !== 2'd0 || {o_inc_hour, o_inc_min, o_inc_sec} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release: mode/inc got %0d/%b expected 0/000",
                     o_setting_mode, {o_inc_hour, o_inc_min, o_inc_sec});
        end
        i_sw_up = 1'b0;
        tick();
    endtask

`ifdef SETTING_AUTO_REPEAT_EN
    task automatic test_auto_repeat;
        logic exp_s;
        tap_idle(0);
        i_sw_up = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_s = (k == 1) || (k == 21) || (k == 26) || (k == 31) || (k == 36);
            checks++;
            if (o_inc_sec !== exp_s || o_inc_min !== 1'b0 || o_inc_hour !== 1'b0) begin
                failures++;
                $display("FAIL auto_repeat[+%0d]: sec got %b expected %b", k, o_inc_sec, exp_s);
            end
        end
        i_sw_up = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (o_inc_sec !== 1'b0) begin
                failures++;
                $display("FAIL repeat_release[%0d]: sec got %b expected 0", k, o_inc_sec);
            end
        end
        tap_idle(0); tap_idle(0); tap_idle(0);
    endtask
`endif

    initial begin
        test_reset();
        test_mode_cycle();
        test_position();
        test_increment();
        test_timeout();
        test_priority();
        test_reset_mid();
`ifdef SETTING_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/setting_ctrl.md
Name: setting_ctrl

Overview:
- Front-panel setting controller for the digital clock.
- Turns three debounced push-switch levels into these outputs:
  - the 2-bit `setting_mode` and `setting_position` that drive the blink/display path;
  - one-cycle increment strobes to the hour/min/sec counters.
- Returns to normal display after an inactivity timeout.
- Sits between the debouncers and the time/alarm counters and blink logic.

Parameters:
- TIMEOUT_CYCLES, 500_000_000: idle cycles in setting modes before auto-exit (10 s at 50 MHz).
- CNT_W, 32: width of the timeout and repeat counters.
- REPEAT_DELAY, 25_000_000: hold time before the first auto-repeat strobe (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5_000_000: spacing of subsequent auto-repeat strobes (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock. One clock; all logic on posedge clk.
- rst_n  in  1  reset, asynchronous, active-low.
- i_sw_mode  in  1  debounced mode switch level, 1 = pressed.
- i_sw_pos  in  1  debounced position switch level.
- i_sw_up  in  1  debounced increment switch level.
- o_setting_mode  out  2  0 clock, 1 time set, 2 alarm set, 3 stopwatch.
- o_setting_position  out  2  0 sec, 1 min, 2 hour.
- o_inc_sec  out  1  one-cycle increment strobe.
- o_inc_min  out  1  one-cycle increment strobe.
- o_inc_hour  out  1  one-cycle increment strobe.
- o_timeout  out  1  one-cycle strobe when auto-exit fires.

Behaviour:
- **Reset (async, rst_n=0):**
  - mode=0, position=0.
  - All strobes 0.
  - Previous-level registers 0.
  - Counters 0.
- **Press detection:** press = i_sw & ~prev; prev is registered each cycle. A switch held high at reset release does not count as a press.
- **Output timing:** all outputs are registered. A response appears one cycle after the first cycle the input is sampled high.
- **Priority within one cycle:** mode press > pos press > up press. Lower-priority presses in that cycle are discarded, not queued.
- **Mode press:** mode advances 0→1→2→3→0; position is forced to 0.
- **Pos press:**
  - In mode 1 or 2: position advances 0→1→2→0. A position value of 3 is unreachable; if it occurs, the next value is 0.
  - In mode 0 or 3: ignored; position stays 0.
- **Up press:**
  - In mode 1 or 2: one-cycle strobe on o_inc_sec, o_inc_min or o_inc_hour, selected by position 0, 1 or 2.
  - In mode 0 or 3: no strobe.
  - Strobes are mutually exclusive.
- **Timeout counter:**
  - Cleared on any press, any mode change, and in modes 0 and 3.
  - Increments each cycle in modes 1 and 2.
  - On the cycle it equals TIMEOUT_CYCLES-1: next cycle mode=0, position=0, o_timeout=1 for one cycle, counter cleared.
  - If a press occurs in the same cycle as expiry, the press wins and the timeout does not fire.
- **Stopwatch mode:** mode 3 never times out.
- **Reset mid-operation:** everything returns to reset values immediately; no strobe is emitted.

Optional Feature:
- Macro: SETTING_AUTO_REPEAT_EN.
- **Defined:**
  - While i_sw_up is held in mode 1 or 2, a hold counter runs.
  - After REPEAT_DELAY cycles past the initial strobe, a further strobe fires, then one every REPEAT_PERIOD cycles.
  - Each repeat strobe clears the timeout counter.
  - Release, mode change or pos press clears the hold counter.
- **Undefined:** exactly one strobe per rising edge; REPEAT_* parameters unused and no hold counter is built.

Decomposition:
- **Package setting_pkg:**
  - MODE_CLOCK=0, MODE_TSET=1, MODE_ASET=2, MODE_SW=3.
  - POS_SEC=0, POS_MIN=1, POS_HOUR=2.
  - Helper function is_set_mode(mode).
- **Sub-module sw_edge:** instantiated three times. Registers the prev level and outputs the press pulse. Ports: clk, rst_n, i_lvl, o_press.
- The FSM and counters stay in setting_ctrl.

Test Plan:
1. Reset, then 4 mode presses → mode 1, 2, 3, 0, each one cycle after its press; position 0 throughout.
2. Mode 1, pos press ×3 → position 1, 2, 0. Pos press in mode 0 → position stays 0.
3. Mode 1, position 1, up press (high 5 cycles) → o_inc_min=1 for exactly one cycle; other strobes 0. Same in mode 3 → no strobe.
4. Mode 2 with TIMEOUT_CYCLES=100, no presses:
   - o_timeout strobe after 100 cycles; mode 0, position 0.
   - Repeat with a press at cycle 99 → no timeout.
5. Mode press and up press in the same cycle (mode 1) → mode 2, position 0, no inc strobe.
6. With SETTING_AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold up 40 cycles in mode 1, position 0 → o_inc_sec strobes at press+1, +21, +26, +31, +36 only.
